lsu_pipelined: RTL and testbench

Next-generation load/store unit for the MEM stage. It replaces the single-outstanding lsu with a pipelined Avalon-MM master that keeps up to MAX_OUTSTANDING loads in flight, using readdatavalid for completion. Per-load metadata (opcode, byte offset) is queued in a small FIFO. Returned data is aligned and sign/zero-extended, then delivered to the WB path in order. Stores are posted (fire-and-forget).

---
 rtl/lsu_pipelined_pkg.sv | 18 +
 rtl/lsu_pipelined_pend_fifo.sv | 61 ++++++
 rtl/lsu_pipelined.sv | 121 ++++++++++++
 tb/tb_lsu_pipelined.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pipelined_pkg.sv
// Shared types for the pipelined load/store unit.
//   - RV32 funct3 load/store encodings
//   - lsu_pend_t: per-load metadata kept while the bus read is in flight
package lsu_pipelined_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] offset;
    logic       discard;
  } lsu_pend_t;

endpackage

// File: rtl/lsu_pipelined_pend_fifo.sv
// In-order FIFO of pending-load metadata.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   push, push_data  enqueue one entry
//   pop              dequeue head (caller guarantees !empty)
//   flush            mark every resident entry discard
//   head             current head entry
//   count            occupancy; full / empty flags
module lsu_pipelined_pend_fifo
  import lsu_pipelined_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  lsu_pend_t     push_data,
  input  logic          pop,
  input  logic          flush,
  output lsu_pend_t     head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [2:0]       op_q  [DEPTH];
  logic [1:0]       off_q [DEPTH];
  logic [DEPTH-1:0] disc_q;
  logic [PW-1:0]    wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      disc_q <= '0;
    end else begin
      // Bulk-set covers empty slots too; harmless, a push rewrites its own bit.
      if (flush) disc_q <= '1;
      if (push) begin
        op_q[wr_ptr]   <= push_data.opcode;
        off_q[wr_ptr]  <= push_data.offset;
        disc_q[wr_ptr] <= push_data.discard;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = '{opcode: op_q[rd_ptr], offset: off_q[rd_ptr], discard: disc_q[rd_ptr]};
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/lsu_pipelined.sv
// Pipelined load/store unit: Avalon-MM master with up to MAX_OUTSTANDING
// loads in flight, in-order completion via readdatavalid, posted stores.
// Ports: clk/rst (sync active-high), lsu_* request/response side,
//   dbus_* Avalon-MM master side.
// Optional: define LSU_RESP_BYPASS_EN for a combinational (0-latency)
//   response path; default is a registered response one cycle after
//   readdatavalid.
module lsu_pipelined
  import lsu_pipelined_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_mem_read,
  input  logic                  lsu_mem_write,
  input  logic [2:0]            lsu_mem_opcode,
  input  logic [ADDR_WIDTH-1:0] lsu_address,
  input  logic [31:0]           lsu_writedata,
  input  logic                  lsu_flush,
  output logic                  lsu_req_ready,
  output logic                  lsu_resp_valid,
  output logic [31:0]           lsu_readdata,
  output logic                  lsu_dbus_busy,
  output logic                  lsu_exception_load_addr_misaligned,
  output logic                  lsu_exception_store_addr_misaligned,
  output logic                  dbus_read,
  output logic                  dbus_write,
  output logic [ADDR_WIDTH-1:0] dbus_address,
  output logic [3:0]            dbus_byteenable,
  output logic [31:0]           dbus_writedata,
  input  logic                  dbus_waitrequest,
  input  logic [31:0]           dbus_readdata,
  input  logic                  dbus_readdatavalid
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic          is_half, is_word, misaligned;
  logic          full, empty, push, pop, resp_fire;
  logic [CW-1:0] count;
  lsu_pend_t     head;
  logic [31:0]   lane, ext;

  // Size decode on funct3[1:0] serves both loads and stores (U bit ignored).
  assign is_half    = (lsu_mem_opcode[1:0] == 2'b01);
  assign is_word    = (lsu_mem_opcode[1:0] == 2'b10);
  assign misaligned = (is_half & lsu_address[0]) | (is_word & (lsu_address[1:0] != 2'b00));

  assign lsu_exception_load_addr_misaligned  = lsu_mem_read  & misaligned;
  assign lsu_exception_store_addr_misaligned = lsu_mem_write & misaligned;

  assign dbus_read     = lsu_mem_read  & ~misaligned & ~full;
  assign dbus_write    = lsu_mem_write & ~misaligned;
  assign lsu_req_ready = ~(lsu_mem_read | lsu_mem_write) | misaligned
                       | (~dbus_waitrequest & ~(lsu_mem_read & full));
  assign dbus_address  = {lsu_address[ADDR_WIDTH-1:2], 2'b00};
  assign lsu_dbus_busy = (count != '0);

  always_comb begin
    dbus_byteenable = 4'b1111;
    dbus_writedata  = lsu_writedata;
    if (is_half) begin
      dbus_byteenable = 4'b0011 << lsu_address[1:0];
      dbus_writedata  = {2{lsu_writedata[15:0]}};
    end else if (!is_word) begin
      dbus_byteenable = 4'b0001 << lsu_address[1:0];
      dbus_writedata  = {4{lsu_writedata[7:0]}};
    end
  end

  assign push = dbus_read & ~dbus_waitrequest;
  // Stray readdatavalid with nothing outstanding is dropped here.
  assign pop  = dbus_readdatavalid & ~empty;

  lsu_pipelined_pend_fifo #(.DEPTH(MAX_OUTSTANDING)) u_pend (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ('{opcode: lsu_mem_opcode, offset: lsu_address[1:0], discard: lsu_flush}),
    .pop       (pop),
    .flush     (lsu_flush),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Words are always at offset 0, so lane equals the raw data for them.
  assign lane = dbus_readdata >> {head.offset, 3'b000};

  always_comb begin
    case (head.opcode)
      F3_B:    ext = {{24{lane[7]}}, lane[7:0]};
      F3_H:    ext = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   ext = {24'd0, lane[7:0]};
      F3_HU:   ext = {16'd0, lane[15:0]};
      default: ext = lane;
    endcase
  end

  // The head being popped is itself outstanding at a flush edge.
  assign resp_fire = pop & ~head.discard & ~lsu_flush;

`ifdef LSU_RESP_BYPASS_EN
  assign lsu_resp_valid = resp_fire;
  assign lsu_readdata   = ext;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      lsu_resp_valid <= 1'b0;
      lsu_readdata   <= '0;
    end else begin
      lsu_resp_valid <= resp_fire;
      if (resp_fire) lsu_readdata <= ext;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_pipelined.sv
// Self-checking bench for lsu_pipelined: directed scenarios then random
// traffic, all checked against a queue-based reference model.
module tb_lsu_pipelined;

  localparam int MAXO = 4;

  logic        clk, rst;
  logic        rd, wr, flush, wait_r, rdv;
  logic [2:0]  op;
  logic [31:0] addr, wdata, rdata;

  logic        req_ready, resp_valid, busy, exl, exs, d_rd, d_wr;
  logic [31:0] readdata, d_addr, d_wdata;
  logic [3:0]  d_be;

  lsu_pipelined #(.ADDR_WIDTH(32), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .lsu_mem_read(rd), .lsu_mem_write(wr), .lsu_mem_opcode(op),
    .lsu_address(addr), .lsu_writedata(wdata), .lsu_flush(flush),
    .lsu_req_ready(req_ready), .lsu_resp_valid(resp_valid), .lsu_readdata(readdata),
    .lsu_dbus_busy(busy),
    .lsu_exception_load_addr_misaligned(exl),
    .lsu_exception_store_addr_misaligned(exs),
    .dbus_read(d_rd), .dbus_write(d_wr), .dbus_address(d_addr),
    .dbus_byteenable(d_be), .dbus_writedata(d_wdata),
    .dbus_waitrequest(wait_r), .dbus_readdata(rdata), .dbus_readdatavalid(rdv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {int op; int off; bit disc;} pend_t;
  pend_t       q[$];
  logic        exp_valid;
  logic [31:0] exp_data;
  int          nvec = 0, nerr = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] extract(int o, int off, logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * off)) % 256;
    h = (d >> (8 * off)) % 65536;
    case (o)
      0: return (b >= 128) ? b - 256 : b;
      1: return (h >= 32768) ? h - 65536 : h;
      4: return b;
      5: return h;
      default: return d;
    endcase
  endfunction

  // One cycle: check combinational outputs mid-cycle, advance the model at
  // the edge, then check the registered response just after it.
  task automatic step();
    bit is_h, is_w, mis, full, e_rd, e_wr, e_rdy;
    int off;
    #3;
    off  = int'(addr % 4);
    is_h = (op == 1 || op == 5);
    is_w = (op == 2);
    mis  = (is_h && (off % 2) != 0) || (is_w && off != 0);
    full = (q.size() == MAXO);
    e_rd = rd && !mis && !full;
    e_wr = wr && !mis;
    e_rdy = !(rd || wr) || mis || (!wait_r && !(rd && full));
    chk("dbus_read",  32'(d_rd),      32'(e_rd));
    chk("dbus_write", 32'(d_wr),      32'(e_wr));
    chk("req_ready",  32'(req_ready), 32'(e_rdy));
    chk("exc_load",   32'(exl),       32'(rd && mis));
    chk("exc_store",  32'(exs),       32'(wr && mis));
    chk("busy",       32'(busy),      32'(q.size() != 0));
    if (e_rd || e_wr) begin
      chk("address", d_addr, addr - off);
      chk("byteenable", 32'(d_be), is_w ? 15 : is_h ? (3 << off) : (1 << off));
    end
    if (e_wr)
      chk("writedata", d_wdata, is_w ? wdata :
                                is_h ? (wdata % 65536) * 32'h0001_0001 :
                                       (wdata % 256) * 32'h0101_0101);
    @(posedge clk);
    if (rst) begin
      q.delete();
      exp_valid = 1'b0;
      exp_data  = 32'd0;
    end else begin
      exp_valid = 1'b0;
      if (rdv && q.size() > 0) begin
        pend_t e;
        e = q.pop_front();
        if (!e.disc && !flush) begin
          exp_valid = 1'b1;
          exp_data  = extract(e.op, e.off, rdata);
        end
      end
      if (flush) foreach (q[i]) q[i].disc = 1'b1;
      if (e_rd && !wait_r) q.push_back('{int'(op), off, flush});
    end
    #1;
    chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
    chk("readdata",   readdata,        exp_data);
  endtask

  task automatic idle();
    rd = 0; wr = 0; flush = 0; rdv = 0; wait_r = 0; rst = 0;
  endtask

  task automatic load(logic [2:0] o, logic [31:0] a);
    idle(); rd = 1; op = o; addr = a;
  endtask

  task automatic store(logic [2:0] o, logic [31:0] a, logic [31:0] d);
    idle(); wr = 1; op = o; addr = a; wdata = d;
  endtask

  task automatic ret(logic [31:0] d);
    idle(); rdv = 1; rdata = d;
  endtask

  int unsigned ld_ops[5] = '{0, 1, 2, 4, 5};

  initial begin
    idle(); op = 0; addr = 0; wdata = 0; rdata = 0;
    q.delete(); exp_valid = 0; exp_data = 0;
    rst = 1;
    @(posedge clk); #1;
    step();
    chk("reset_valid", 32'(resp_valid), 32'd0);
    chk("reset_data",  readdata,        32'd0);

    // LW @0x100, data returns three cycles after issue
    load(2, 32'h100); step();
    idle(); step(); step();
    ret(32'hDEAD_BEEF); step();
    chk("lw_valid", 32'(resp_valid), 32'd1);
    chk("lw_data",  readdata,        32'hDEAD_BEEF);

    // LB / LBU @0x103
    load(0, 32'h103); step();
    ret(32'h80FF_FF7F); step();
    chk("lb_sext", readdata, 32'hFFFF_FF80);
    load(4, 32'h103); step();
    ret(32'h80FF_FF7F); step();
    chk("lbu_zext", readdata, 32'h0000_0080);

    // Five back-to-back LW: four fill the FIFO, the fifth waits for a return
    load(2, 32'h200);
    repeat (6) step();
    rdv = 1; rdata = 32'h1111_2222; step();
    chk("full_pop_stall", 32'(q.size()), 32'd3);
    rdv = 0; step();
    chk("accept_after_pop", 32'(q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin ret(32'h3000_0000 + i); step(); end

    // Flush discards three in-flight loads; a later LW completes normally
    for (int i = 0; i < 3; i++) begin load(2, 32'h300 + 4 * i); step(); end
    idle(); flush = 1; step();
    for (int i = 0; i < 3; i++) begin ret(32'hBAD0_0000 + i); step(); end
    chk("flush_busy", 32'(busy), 32'd0);
    load(2, 32'h400); step();
    ret(32'h600D_F00D); step();
    chk("after_flush", readdata, 32'h600D_F00D);

    // Stores: misaligned SH, then aligned SH with lane replication
    store(1, 32'h101, 32'h1234); step();
    store(1, 32'h102, 32'h1234); step();

    // Reset with loads outstanding, then stray returns
    load(2, 32'h500); step();
    load(2, 32'h504); step();
    idle(); rst = 1; step();
    idle();
    ret(32'h7777_7777); step(); step();
    chk("stray_busy", 32'(busy), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int k;
      k      = $urandom_range(0, 3);
      rst    = ($urandom_range(0, 63) == 0);
      rd     = (k < 2);
      wr     = (k == 2);
      op     = rd ? 3'(ld_ops[$urandom_range(0, 4)]) : 3'($urandom_range(0, 2));
      addr   = $urandom;
      wdata  = $urandom;
      rdata  = $urandom;
      flush  = ($urandom_range(0, 15) == 0);
      wait_r = ($urandom_range(0, 3) == 0);
      rdv    = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
